freq_monitor: RTL and testbench
===============================

// Module: freq_monitor
// PURPOSE
//  Consumes the per-window frequency results of the frequency calculator (freq_cal), in MHz.
//  Block-averages 2**AVG_LOG2 samples and checks each average against a window with hysteresis.
//  Raises lock and low/high alarm flags for the control/status logic downstream of measurement.
// PARAMETERS
//  WIDTH      32  width of frequency input/average, unsigned MHz
//  AVG_LOG2   2   log2 of samples per average (0 = no averaging)
//  LOW_LIMIT  45  lowest in-range average, MHz
//  HIGH_LIMIT 55  highest in-range average, MHz
//  HYST       2   extra margin each side while LOCKED, MHz
//  LOCK_COUNT 3   consecutive in-range averages needed to lock (>=1)
// PORTS
//  clk        in   1      system clock
//  rst        in   1      async reset, active-high
//  clear      in   1      sync soft restart: behaves as reset, no state retained
//  freq_in    in   WIDTH  measured frequency, MHz, unsigned
//  freq_valid in   1      freq_in valid this cycle; may be high back-to-back
//  avg_freq   out  WIDTH  last completed average, held until next
//  avg_valid  out  1      1-cycle pulse when avg_freq updates
//  in_range   out  1      high only in LOCKED
//  alarm_low  out  1      high in ALARM when last average was below window
//  alarm_high out  1      high in ALARM when last average was above window
//  state      out  2      IDLE=0 ACQUIRE=1 LOCKED=2 ALARM=3
// BEHAVIOUR
//  - Clock clk, reset rst: one clock; rst is asynchronous and active-high.
//  - Reset (rst, or clear at a clock edge): all outputs 0, state IDLE. Accumulator, sample
//    count and match count cleared. A partial accumulation is discarded.
//  - clear has priority over freq_valid in the same cycle; that sample is dropped.
//  - Accumulator width is WIDTH+AVG_LOG2, so it never overflows.
//  - Each freq_valid adds freq_in to the accumulator and increments the sample count.
//  - On the 2**AVG_LOG2-th sample:
//      avg_freq <= (acc+freq_in)>>AVG_LOG2 (truncated);
//      the accumulator restarts at 0 with no lost sample.
//  - Latency: avg_valid and avg_freq are asserted the cycle after the edge that captured
//    the final sample.
//  - FSM evaluates each new average A one cycle after it appears, so state and flags change
//    2 cycles after the final sample.
//  - Strict window S: LOW_LIMIT<=A<=HIGH_LIMIT.
//  - Wide window W: LOW_LIMIT-HYST<=A<=HIGH_LIMIT+HYST. W is computed without underflow;
//    the lower bound saturates at 0.
//  - IDLE/ALARM:
//      A in S -> ACQUIRE with match=1, or LOCKED directly if LOCK_COUNT==1;
//      otherwise -> ALARM.
//  - ACQUIRE:
//      A in S: match++, and -> LOCKED when match reaches LOCK_COUNT;
//      A not in S -> ALARM, match=0.
//  - LOCKED: stays while A in W; A outside W -> ALARM.
//  - On entry to or within ALARM:
//      A<lower bound -> alarm_low=1, alarm_high=0;
//      A>upper bound -> alarm_high=1, alarm_low=0.
//    Both flags clear on leaving ALARM. They are never both high.
//  - Between averages, state and flags hold. freq_valid gaps of any length are allowed.
// TESTING (defaults)
//  T1 Reset: assert rst mid-accumulation.
//     -> all outputs 0, state 0 asynchronously.
//     After release, 4 more samples are needed for the next avg_valid.
//  T2 Lock: 12 back-to-back samples of 50.
//     -> avg_valid pulses the cycle after samples 4, 8, 12, with avg_freq=50.
//     -> State goes ACQUIRE after 1st average, LOCKED after 3rd; in_range=1.
//  T3 Truncation: samples 50,50,50,51 -> avg_freq=50. Samples 0,0,0,3 -> avg_freq=0.
//  T4 Hysteresis: from LOCKED, average 57 -> stays LOCKED.
//     Next average 58 -> ALARM with alarm_high=1, in_range=0.
//     Next 56 -> stays ALARM. Next 50 -> ACQUIRE, alarms 0.
//  T5 Low side: from IDLE, average 10 -> ALARM, alarm_low=1.
//     Then 60 -> ALARM, alarm_high=1, alarm_low=0.
//  T6 clear: clear after 2 samples, asserted together with a 3rd sample of 99.
//     -> 99 is dropped; the next 4 samples of 48 give avg_freq=48 and state ACQUIRE.

Source files
------------

// File: rtl/freq_monitor.sv
// Block-averaging frequency monitor with a hysteresis window.
// Produces lock and low/high alarm flags from the averaged frequency.
module freq_monitor #(
  parameter int WIDTH      = 32,
  parameter int AVG_LOG2   = 2,
  parameter int LOW_LIMIT  = 45,
  parameter int HIGH_LIMIT = 55,
  parameter int HYST       = 2,
  parameter int LOCK_COUNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] freq_in,
  input  logic             freq_valid,
  output logic [WIDTH-1:0] avg_freq,
  output logic             avg_valid,
  output logic             in_range,
  output logic             alarm_low,
  output logic             alarm_high,
  output logic [1:0]       state
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int AW = WIDTH + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int WL = (LOW_LIMIT > HYST) ? LOW_LIMIT - HYST : 0;

  localparam logic [WIDTH:0] S_LO = (WIDTH+1)'(LOW_LIMIT);
  localparam logic [WIDTH:0] S_HI = (WIDTH+1)'(HIGH_LIMIT);
  localparam logic [WIDTH:0] W_LO = (WIDTH+1)'(WL);
  localparam logic [WIDTH:0] W_HI = (WIDTH+1)'(HIGH_LIMIT + HYST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    ALARM   = 2'd3
  } state_t;

  state_t          st;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [MW-1:0]   match;
  logic [AW-1:0]   sum;
  logic            last;
  logic [WIDTH:0]  a;
  logic [WIDTH:0]  lo;
  logic [WIDTH:0]  hi;
  logic            in_s;
  logic            in_w;
  logic            below;
  logic            lock_now;

  assign sum  = acc + AW'(freq_in);
  assign last = (cnt == CW'(N - 1));
  assign a    = {1'b0, avg_freq};
  assign in_s = (a >= S_LO) && (a <= S_HI);
  assign in_w = (a >= W_LO) && (a <= W_HI);

  // LOCKED judges against the wide window, all other states the strict one
  assign lo    = (st == LOCKED) ? W_LO : S_LO;
  assign hi    = (st == LOCKED) ? W_HI : S_HI;
  assign below = (a < lo);

  assign lock_now = (int'(match) + 1 >= LOCK_COUNT);
  assign state    = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      match      <= '0;
      avg_freq   <= '0;
      avg_valid  <= 1'b0;
      in_range   <= 1'b0;
      alarm_low  <= 1'b0;
      alarm_high <= 1'b0;
    end else if (clear) begin
      st         <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      match      <= '0;
      avg_freq   <= '0;
      avg_valid  <= 1'b0;
      in_range   <= 1'b0;
      alarm_low  <= 1'b0;
      alarm_high <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (freq_valid) begin
        if (last) begin
          avg_freq  <= WIDTH'(sum >> AVG_LOG2);
          avg_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
      if (avg_valid) begin
        unique case (st)
          IDLE, ALARM: begin
            if (in_s) begin
              alarm_low  <= 1'b0;
              alarm_high <= 1'b0;
              if (LOCK_COUNT == 1) begin
                st       <= LOCKED;
                in_range <= 1'b1;
                match    <= '0;
              end else begin
                st    <= ACQUIRE;
                match <= MW'(1);
              end
            end else begin
              st         <= ALARM;
              alarm_low  <= below;
              alarm_high <= !below;
            end
          end
          ACQUIRE: begin
            if (in_s) begin
              match <= match + 1'b1;
              if (lock_now) begin
                st       <= LOCKED;
                in_range <= 1'b1;
              end
            end else begin
              st         <= ALARM;
              match      <= '0;
              alarm_low  <= below;
              alarm_high <= !below;
            end
          end
          LOCKED: begin
            if (!in_w) begin
              st         <= ALARM;
              match      <= '0;
              in_range   <= 1'b0;
              alarm_low  <= below;
              alarm_high <= !below;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_monitor.sv
// Directed testbench for freq_monitor with default parameters.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_freq_monitor;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [31:0] freq_in;
  logic        freq_valid;
  logic [31:0] avg_freq;
  logic        avg_valid;
  logic        in_range;
  logic        alarm_low;
  logic        alarm_high;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  freq_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .freq_in    (freq_in),
    .freq_valid (freq_valid),
    .avg_freq   (avg_freq),
    .avg_valid  (avg_valid),
    .in_range   (in_range),
    .alarm_low  (alarm_low),
    .alarm_high (alarm_high),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [31:0] v);
    freq_in    = v;
    freq_valid = 1'b1;
    @(negedge clk);
    freq_valid = 1'b0;
  endtask

  task automatic avg4(input logic [31:0] v);
    repeat (4) push(v);
    tick(1);
  endtask

  task automatic pulse_rst;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_cmp++;
    if ({avg_freq, avg_valid, in_range, alarm_low, alarm_high, state} !== 38'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got state=%0d avg=%0d flags=%b%b%b%b want all 0",
               state, avg_freq, avg_valid, in_range, alarm_low, alarm_high);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_lock;
    for (int i = 1; i <= 12; i++) begin
      push(32'd50);
      n_cmp++;
      if (avg_valid !== (i % 4 == 0)) begin
        n_bad++;
        $display("FAIL lock_avg_valid[%0d]: got %b want %b", i, avg_valid, (i % 4 == 0));
      end
      if (i % 4 == 0) begin
        n_cmp++;
        if (avg_freq !== 32'd50) begin
          n_bad++;
          $display("FAIL lock_avg_freq[%0d]: got %0d want 50", i, avg_freq);
        end
      end
      if (i == 4) begin
        n_cmp++;
        if (state !== 2'd0) begin
          n_bad++;
          $display("FAIL lock_state_pre: got %0d want 0", state);
        end
      end
      if (i == 5 || i == 9) begin
        n_cmp++;
        if (state !== 2'd1) begin
          n_bad++;
          $display("FAIL lock_state_acq[%0d]: got %0d want 1", i, state);
        end
      end
    end
    tick(1);
    n_cmp++;
    if (state !== 2'd2 || in_range !== 1'b1) begin
      n_bad++;
      $display("FAIL lock_locked: got state=%0d in_range=%b want 2/1", state, in_range);
    end
  endtask

  task automatic test_async_reset;
    push(32'd50);
    push(32'd50);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({avg_freq, avg_valid, in_range, alarm_low, alarm_high, state} !== 38'd0) begin
      n_bad++;
      $display("FAIL async_reset: got state=%0d avg=%0d in_range=%b want all 0",
               state, avg_freq, in_range);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      push(32'd50);
      n_cmp++;
      if (avg_valid !== (i == 4)) begin
        n_bad++;
        $display("FAIL post_reset_valid[%0d]: got %b want %b", i, avg_valid, (i == 4));
      end
    end
    n_cmp++;
    if (avg_freq !== 32'd50) begin
      n_bad++;
      $display("FAIL post_reset_avg: got %0d want 50", avg_freq);
    end
    tick(1);
    n_cmp++;
    if (state !== 2'd1) begin
      n_bad++;
      $display("FAIL post_reset_state: got %0d want 1", state);
    end
  endtask

  task automatic test_truncation;
    push(32'd50);
    push(32'd50);
    push(32'd50);
    push(32'd51);
    n_cmp++;
    if (avg_valid !== 1'b1 || avg_freq !== 32'd50) begin
      n_bad++;
      $display("FAIL trunc_50: got valid=%b avg=%0d want 1/50", avg_valid, avg_freq);
    end
    tick(1);
    push(32'd0);
    push(32'd0);
    push(32'd0);
    push(32'd3);
    n_cmp++;
    if (avg_valid !== 1'b1 || avg_freq !== 32'd0) begin
      n_bad++;
      $display("FAIL trunc_0: got valid=%b avg=%0d want 1/0", avg_valid, avg_freq);
    end
    tick(1);
    n_cmp++;
    if (state !== 2'd3 || alarm_low !== 1'b1 || alarm_high !== 1'b0) begin
      n_bad++;
      $display("FAIL trunc_alarm: got state=%0d lo=%b hi=%b want 3/1/0",
               state, alarm_low, alarm_high);
    end
  endtask

  task automatic test_hysteresis;
    avg4(32'd50);
    avg4(32'd50);
    avg4(32'd50);
    n_cmp++;
    if (state !== 2'd2) begin
      n_bad++;
      $display("FAIL hyst_relock: got state=%0d want 2", state);
    end
    avg4(32'd57);
    n_cmp++;
    if (state !== 2'd2 || in_range !== 1'b1) begin
      n_bad++;
      $display("FAIL hyst_57: got state=%0d in_range=%b want 2/1", state, in_range);
    end
    avg4(32'd58);
    n_cmp++;
    if (state !== 2'd3 || alarm_high !== 1'b1 || alarm_low !== 1'b0 || in_range !== 1'b0) begin
      n_bad++;
      $display("FAIL hyst_58: got state=%0d hi=%b lo=%b in_range=%b want 3/1/0/0",
               state, alarm_high, alarm_low, in_range);
    end
    avg4(32'd56);
    n_cmp++;
    if (state !== 2'd3 || alarm_high !== 1'b1) begin
      n_bad++;
      $display("FAIL hyst_56: got state=%0d hi=%b want 3/1", state, alarm_high);
    end
    avg4(32'd50);
    n_cmp++;
    if (state !== 2'd1 || alarm_high !== 1'b0 || alarm_low !== 1'b0) begin
      n_bad++;
      $display("FAIL hyst_50: got state=%0d hi=%b lo=%b want 1/0/0",
               state, alarm_high, alarm_low);
    end
  endtask

  task automatic test_low_side;
    pulse_rst();
    avg4(32'd10);
    n_cmp++;
    if (state !== 2'd3 || alarm_low !== 1'b1 || alarm_high !== 1'b0) begin
      n_bad++;
      $display("FAIL low_10: got state=%0d lo=%b hi=%b want 3/1/0",
               state, alarm_low, alarm_high);
    end
    avg4(32'd60);
    n_cmp++;
    if (state !== 2'd3 || alarm_high !== 1'b1 || alarm_low !== 1'b0) begin
      n_bad++;
      $display("FAIL low_60: got state=%0d hi=%b lo=%b want 3/1/0",
               state, alarm_high, alarm_low);
    end
  endtask

  task automatic test_clear;
    push(32'd48);
    push(32'd48);
    freq_in    = 32'd99;
    freq_valid = 1'b1;
    clear      = 1'b1;
    @(negedge clk);
    freq_valid = 1'b0;
    clear      = 1'b0;
    n_cmp++;
    if (state !== 2'd0 || avg_freq !== 32'd0 || alarm_high !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_state: got state=%0d avg=%0d hi=%b want 0/0/0",
               state, avg_freq, alarm_high);
    end
    for (int i = 1; i <= 4; i++) begin
      push(32'd48);
      n_cmp++;
      if (avg_valid !== (i == 4)) begin
        n_bad++;
        $display("FAIL clear_valid[%0d]: got %b want %b", i, avg_valid, (i == 4));
      end
    end
    n_cmp++;
    if (avg_freq !== 32'd48) begin
      n_bad++;
      $display("FAIL clear_avg: got %0d want 48", avg_freq);
    end
    tick(1);
    n_cmp++;
    if (state !== 2'd1) begin
      n_bad++;
      $display("FAIL clear_acquire: got state=%0d want 1", state);
    end
  endtask

  initial begin
    rst        = 1'b1;
    clear      = 1'b0;
    freq_in    = '0;
    freq_valid = 1'b0;
    test_reset();
    test_lock();
    test_async_reset();
    test_truncation();
    test_hysteresis();
    test_low_side();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
